ram_sync_nolatch_nrnw_clr: RTL and testbench
============================================

Name: ram_sync_nolatch_nrnw_clr

Overview:
- Generalised multi-port register-file RAM: NR asynchronous read ports, NW synchronous write ports, parametrised width and depth.
- Adds three behaviours the fixed 2r1w/2r2w/4r2w RAMs lack: deterministic write-port priority, optional same-cycle write-to-read bypass, and a hardware clear sweep on reset or on request.
- Drop-in for rename tables, free lists and ARF/RRF storage where a known post-reset state and forwarding are required.

Parameters:
- BRAM_ADDR_WIDTH, `ADDR_LEN, address bits per port.
- BRAM_DATA_WIDTH, `DATA_LEN, data bits per entry.
- DATA_DEPTH, 32, number of entries; 1 <= DATA_DEPTH <= 2**BRAM_ADDR_WIDTH.
- NUM_RD, 4, read port count (>= 1).
- NUM_WR, 2, write port count (>= 1).
- BYPASS, 0, 1 = same-cycle write data forwarded to matching reads.
- INIT_VALUE, 0, value every entry holds after a clear sweep (BRAM_DATA_WIDTH bits).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_x  in  1  asynchronous active-low reset.
- raddr  in  NUM_RD*BRAM_ADDR_WIDTH  packed read addresses, port i at [i*AW +: AW].
- rdata  out  NUM_RD*BRAM_DATA_WIDTH  packed read data, port i at [i*DW +: DW].
- waddr  in  NUM_WR*BRAM_ADDR_WIDTH  packed write addresses.
- wdata  in  NUM_WR*BRAM_DATA_WIDTH  packed write data.
- we  in  NUM_WR  per-port write enable.
- clear_req  in  1  single-cycle pulse requesting a full clear sweep.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Clock/reset: one clock, clk; reset_x is asynchronous, active-low. Storage array is not reset directly; only control state is.
- FSM states: CLEAR, IDLE. reset_x low forces state=CLEAR, sweep counter=0, busy=1 immediately, asynchronously.
- CLEAR: each cycle, mem[counter] <= INIT_VALUE, counter += 1. When the write at counter = DATA_DEPTH-1 happens, next state is IDLE with counter=0. A sweep takes exactly DATA_DEPTH cycles after reset release; busy falls on the edge that writes the last entry.
- CLEAR: all we ignored. clear_req ignored, so the sweep is neither restarted nor extended. Every rdata port reads INIT_VALUE, regardless of array contents or BYPASS.
- IDLE: busy=0. clear_req=1 at an edge moves the FSM to CLEAR (counter=0). Writes presented in that same cycle are still performed, then overwritten by the sweep.
- Reads, IDLE: combinational, zero latency. rdata_i = mem[raddr_i] holds the value written at the most recent prior edge.
- Reads with raddr_i >= DATA_DEPTH return all zeros.
- Writes: at rising edge, for each port j with we[j]=1 and waddr_j < DATA_DEPTH, mem[waddr_j] <= wdata_j. Out-of-range writes are dropped silently.
- Write collision: several enabled ports with the same address means the highest-index port wins. Deterministic, no X.
- BYPASS=1, IDLE: if any enabled, in-range write port matches raddr_i in the same cycle, rdata_i = that port's wdata. The winner is the highest-index matching port, the same rule as the array. Otherwise array data.
- BYPASS=0: the read returns the old value in a same-cycle read/write collision; the new value appears the next cycle.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from entry 0. Contents before the sweep completes are undefined except through the masked INIT_VALUE read.
- Widths: counter is $clog2(DATA_DEPTH) bits, minimum 1. No arithmetic on data.

Decomposition:
- `ADDR_LEN / `DATA_LEN come from constants.vh.
- Add to the shared constants header: the FSM state encodings (RAM_ST_IDLE=1'b0, RAM_ST_CLEAR=1'b1) and a clog2 helper macro/function usable by sibling RAMs.
- One natural sub-module: ram_wport_prio_sel.
  - Inputs: one query address, NUM_WR write addr/data/en vectors, DATA_DEPTH.
  - Outputs: hit and the winning data, highest index first.
  - Instantiated once per array entry for write resolution, and once per read port for the bypass path.

Test Plan:
- Reset sweep, DEPTH=32, INIT_VALUE=32'hDEAD_BEEF: hold reset_x low 3 cycles, release → busy=1 for exactly 32 cycles, then 0. All rdata = DEADBEEF throughout and afterwards, for every address 0..31.
- Write collision, NUM_WR=2: we=2'b11, waddr both 5, wdata0=0x11, wdata1=0x22 → next cycle, read of 5 returns 0x22. Repeat with only we[0] → 0x11.
- Bypass, BYPASS=1: write 0xAB to addr 7 while raddr0=7 → rdata0=0xAB in the same cycle. Same stimulus with BYPASS=0 → old value this cycle, 0xAB the next.
- Writes during clear: in IDLE, pulse clear_req, then assert we to addr 3 with 0x55 during CLEAR → write ignored; after busy falls, addr 3 = INIT_VALUE. clear_req pulsed mid-sweep → sweep length unchanged (32 cycles).
- Async reset mid-operation: fill addresses with distinct values, drop reset_x between clock edges → busy=1 immediately with no edge needed, and reads return INIT_VALUE. A full 32-cycle sweep follows release.
- Out-of-range, DEPTH=24, ADDR=5: write to addr 30 → no entry changes; read of addr 30 returns 0. Read of addr 23 after a write of 0x77 returns 0x77.

Source files
------------

// File: rtl/ram_sync_nolatch_nrnw_clr_pkg.sv
// Shared constants for the multi-port register-file RAM family.
//  - default address/data widths used by sibling RAMs
//  - clear-sweep FSM state encodings
//  - ram_clog2: ceil(log2(n)) with a floor of 1, so counters never collapse
//    to zero bits for a single-entry array
package ram_sync_nolatch_nrnw_clr_pkg;

  localparam int ADDR_LEN = 5;
  localparam int DATA_LEN = 32;

  localparam logic [0:0] RAM_ST_IDLE  = 1'b0;
  localparam logic [0:0] RAM_ST_CLEAR = 1'b1;

  function automatic int ram_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_wport_prio_sel.sv
// Write-port priority selector.
// Given one query address, reports whether any enabled, in-range write port
// targets it and returns that port's data. When several ports match, the
// highest-index port wins.
// Ports:
//   qaddr  - address being resolved (array entry index or read address)
//   waddr  - per-port write addresses
//   wdata  - per-port write data
//   we     - per-port write enables
//   hit    - some enabled in-range port matches qaddr
//   data   - data of the winning port ('0 when no hit)
module ram_wport_prio_sel
  import ram_sync_nolatch_nrnw_clr_pkg::*;
#(
  parameter int AW         = ADDR_LEN,
  parameter int DW         = DATA_LEN,
  parameter int NUM_WR     = 2,
  parameter int DATA_DEPTH = 32
) (
  input  logic [AW-1:0]              qaddr,
  input  logic [NUM_WR-1:0][AW-1:0]  waddr,
  input  logic [NUM_WR-1:0][DW-1:0]  wdata,
  input  logic [NUM_WR-1:0]          we,
  output logic                       hit,
  output logic [DW-1:0]              data
);

  // One extra bit so DATA_DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DATA_DEPTH);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan: a later (higher-index) match overrides earlier ones.
    for (int j = 0; j < NUM_WR; j++) begin
      if (we[j] && (waddr[j] == qaddr) && ({1'b0, waddr[j]} < DEPTH_C)) begin
        hit  = 1'b1;
        data = wdata[j];
      end
    end
  end

endmodule

// File: rtl/ram_sync_nolatch_nrnw_clr.sv
// Multi-port register-file RAM with NUM_RD combinational read ports and
// NUM_WR synchronous write ports, deterministic write priority (highest
// port index wins), optional same-cycle write-to-read bypass and a hardware
// clear sweep that runs after reset or on clear_req.
// Ports:
//   clk       - clock, all state on rising edge
//   reset_x   - asynchronous active-low reset of control state
//   raddr     - packed read addresses, port i at [i*AW +: AW]
//   rdata     - packed read data, port i at [i*DW +: DW]
//   waddr     - packed write addresses
//   wdata     - packed write data
//   we        - per-port write enable
//   clear_req - one-cycle pulse starting a full clear sweep (IDLE only)
//   busy      - high while the clear sweep runs
module ram_sync_nolatch_nrnw_clr
  import ram_sync_nolatch_nrnw_clr_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = ADDR_LEN,
  parameter int BRAM_DATA_WIDTH = DATA_LEN,
  parameter int DATA_DEPTH      = 32,
  parameter int NUM_RD          = 4,
  parameter int NUM_WR          = 2,
  parameter int BYPASS          = 0,
  parameter logic [BRAM_DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                 clk,
  input  logic                                 reset_x,
  input  logic [NUM_RD*BRAM_ADDR_WIDTH-1:0]    raddr,
  output logic [NUM_RD*BRAM_DATA_WIDTH-1:0]    rdata,
  input  logic [NUM_WR*BRAM_ADDR_WIDTH-1:0]    waddr,
  input  logic [NUM_WR*BRAM_DATA_WIDTH-1:0]    wdata,
  input  logic [NUM_WR-1:0]                    we,
  input  logic                                 clear_req,
  output logic                                 busy
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam int CW = ram_clog2(DATA_DEPTH);

  // Packed views of the flat port buses (identical bit layout).
  logic [NUM_RD-1:0][AW-1:0] ra;
  logic [NUM_WR-1:0][AW-1:0] wa;
  logic [NUM_WR-1:0][DW-1:0] wd;
  logic [NUM_RD-1:0][DW-1:0] rd;

  assign ra    = raddr;
  assign wa    = waddr;
  assign wd    = wdata;
  assign rdata = rd;

  // ---------------------------------------------------------------------
  // Clear-sweep control
  // ---------------------------------------------------------------------
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clearing;

  assign clearing = (state_q == RAM_ST_CLEAR);
  assign busy     = clearing;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RAM_ST_CLEAR: begin
        // clear_req is ignored here: the sweep is never restarted or extended.
        if (cnt_q == CW'(DATA_DEPTH-1)) begin
          state_d = RAM_ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (clear_req) begin
          state_d = RAM_ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q <= RAM_ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one priority selector per entry resolves the write ports.
  // ---------------------------------------------------------------------
  logic [DATA_DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [DATA_DEPTH-1:0]         ent_hit;
  logic [DATA_DEPTH-1:0][DW-1:0] ent_dat;

  for (genvar e = 0; e < DATA_DEPTH; e++) begin : g_ent
    ram_wport_prio_sel #(
      .AW(AW), .DW(DW), .NUM_WR(NUM_WR), .DATA_DEPTH(DATA_DEPTH)
    ) u_sel (
      .qaddr (AW'(e)),
      .waddr (wa),
      .wdata (wd),
      .we    (we),
      .hit   (ent_hit[e]),
      .data  (ent_dat[e])
    );
  end

  always_comb begin
    mem_d = mem_q;
    for (int e = 0; e < DATA_DEPTH; e++) begin
      if (clearing) begin
        // During the sweep only the entry under the counter changes;
        // port writes are dropped.
        if (cnt_q == CW'(e)) mem_d[e] = INIT_VALUE;
      end else if (ent_hit[e]) begin
        mem_d[e] = ent_dat[e];
      end
    end
  end

  // Array contents are deliberately not reset; the sweep defines them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [NUM_RD-1:0]         byp_hit;
  logic [NUM_RD-1:0][DW-1:0] byp_dat;

  if (BYPASS != 0) begin : g_byp
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rp
      ram_wport_prio_sel #(
        .AW(AW), .DW(DW), .NUM_WR(NUM_WR), .DATA_DEPTH(DATA_DEPTH)
      ) u_byp (
        .qaddr (ra[i]),
        .waddr (wa),
        .wdata (wd),
        .we    (we),
        .hit   (byp_hit[i]),
        .data  (byp_dat[i])
      );
    end
  end else begin : g_nobyp
    assign byp_hit = '0;
    assign byp_dat = '0;
  end

  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      // Explicit compare mux: addresses at or past DATA_DEPTH match nothing
      // and therefore read as zero.
      for (int e = 0; e < DATA_DEPTH; e++) begin
        if (ra[i] == AW'(e)) rd[i] = mem_q[e];
      end
      if ((BYPASS != 0) && byp_hit[i]) rd[i] = byp_dat[i];
      // While sweeping, the array is partly stale; mask every port.
      if (clearing) rd[i] = INIT_VALUE;
    end
  end

endmodule

// File: tb/tb_ram_sync_nolatch_nrnw_clr.sv
module tb_ram_sync_nolatch_nrnw_clr;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam logic [31:0] INIT_A = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              reset_x;
  logic [NR*AW-1:0]  raddr;
  logic [NW*AW-1:0]  waddr;
  logic [NW*DW-1:0]  wdata;
  logic [NW-1:0]     we;
  logic              clear_req;
  logic [NR*DW-1:0]  rdata_a, rdata_b, rdata_c;
  logic              busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  // a: depth 32, no bypass; b: same with bypass; c: depth 24, INIT 0.
  ram_sync_nolatch_nrnw_clr #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(32),
    .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .INIT_VALUE(INIT_A)) dut_a (
    .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata_a), .waddr(waddr),
    .wdata(wdata), .we(we), .clear_req(clear_req), .busy(busy_a));
  ram_sync_nolatch_nrnw_clr #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(32),
    .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .INIT_VALUE(INIT_A)) dut_b (
    .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata_b), .waddr(waddr),
    .wdata(wdata), .we(we), .clear_req(clear_req), .busy(busy_b));
  ram_sync_nolatch_nrnw_clr #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW), .DATA_DEPTH(24),
    .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .INIT_VALUE(32'h0)) dut_c (
    .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata_c), .waddr(waddr),
    .wdata(wdata), .we(we), .clear_req(clear_req), .busy(busy_c));

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];
  int ntests = 0;
  int nfail  = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    ntests++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        nfail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [31:0] pick(input logic [NR*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  task automatic set_r(input int i, input int a);
    raddr[i*AW +: AW] = AW'(a);
  endtask

  task automatic set_w(input int j, input int a, input logic [31:0] d);
    waddr[j*AW +: AW] = AW'(a);
    wdata[j*DW +: DW] = d;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until dut_a's busy falls; records where dut_c's fell.
  task automatic sweep_len(output int n, output int nc);
    n  = 0;
    nc = 0;
    while (busy_a && n < 100) begin
      edge1();
      n++;
      if (!busy_c && nc == 0) nc = n;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nc;
    reset_x = 1'b0; raddr = '0; waddr = '0; wdata = '0; we = '0; clear_req = 1'b0;

    // ---- reset sweep ----
    repeat (3) edge1();
    push("rst_busy", 32'd1);       check(32'(busy_a));
    set_r(0, 9);
    #1;
    push("rst_rd_mask", INIT_A);   check(pick(rdata_a, 0));
    reset_x = 1'b1;
    sweep_len(n, nc);
    push("rst_sweep_len", 32'd32); check(32'(n));
    push("rst_sweep_c", 32'd24);   check(32'(nc));
    push("rst_busy_b", 32'd0);     check(32'(busy_b));
    for (int a = 0; a < 32; a += NR) begin
      for (int i = 0; i < NR; i++) set_r(i, a + i);
      #1;
      for (int i = 0; i < NR; i++) begin
        push($sformatf("init_a%0d", a + i), INIT_A);
        check(pick(rdata_a, i));
      end
    end

    // ---- write collision ----
    set_w(0, 5, 32'h11); set_w(1, 5, 32'h22); we = 2'b11; set_r(0, 5);
    edge1(); we = 2'b00; #1;
    push("coll_hi_wins", 32'h22);  check(pick(rdata_a, 0));
    we = 2'b01;
    edge1(); we = 2'b00; #1;
    push("coll_p0_only", 32'h11);  check(pick(rdata_a, 0));

    // ---- bypass ----
    set_w(0, 7, 32'h01); we = 2'b01;
    edge1(); we = 2'b00;
    set_r(0, 7); set_w(0, 7, 32'hAB); we = 2'b01;
    #1;
    push("byp_fwd", 32'hAB);       check(pick(rdata_b, 0));
    push("nobyp_old", 32'h01);     check(pick(rdata_a, 0));
    edge1(); we = 2'b00; #1;
    push("nobyp_next", 32'hAB);    check(pick(rdata_a, 0));
    set_w(0, 7, 32'hC0); set_w(1, 7, 32'hC1); we = 2'b11;
    #1;
    push("byp_prio", 32'hC1);      check(pick(rdata_b, 0));
    edge1(); we = 2'b00; #1;
    push("byp_prio_arr", 32'hC1);  check(pick(rdata_a, 0));

    // ---- clear request, writes and clear_req during sweep ----
    clear_req = 1'b1;
    edge1(); clear_req = 1'b0;
    push("clr_busy", 32'd1);       check(32'(busy_a));
    set_r(0, 7); set_r(1, 3); set_w(0, 3, 32'h55); we = 2'b01;
    #1;
    push("clr_rd_mask", INIT_A);   check(pick(rdata_a, 0));
    push("clr_byp_mask", INIT_A);  check(pick(rdata_b, 1));
    n = 0;
    while (busy_a && n < 100) begin
      we        = (n < 5) ? 2'b01 : 2'b00;
      clear_req = (n == 10);
      edge1();
      n++;
    end
    we = 2'b00; clear_req = 1'b0;
    push("clr_sweep_len", 32'd32); check(32'(n));
    #1;
    push("clr_wr_drop", INIT_A);   check(pick(rdata_a, 1));
    push("clr_old_gone", INIT_A);  check(pick(rdata_a, 0));

    // ---- async reset mid-operation ----
    set_w(0, 0, 32'hA0); set_w(1, 1, 32'hA1); we = 2'b11;
    edge1();
    set_w(0, 2, 32'hA2); set_w(1, 3, 32'hA3);
    edge1(); we = 2'b00;
    set_r(0, 2); set_r(1, 1);
    #1;
    push("fill_rd2", 32'hA2);      check(pick(rdata_a, 0));
    push("fill_rd1", 32'hA1);      check(pick(rdata_a, 1));
    #2;
    reset_x = 1'b0;
    #1;
    push("arst_busy", 32'd1);      check(32'(busy_a));
    push("arst_rd_mask", INIT_A);  check(pick(rdata_a, 0));
    edge1(); edge1();
    reset_x = 1'b1;
    sweep_len(n, nc);
    push("arst_sweep_len", 32'd32); check(32'(n));
    push("arst_sweep_c", 32'd24);   check(32'(nc));

    // ---- out-of-range (dut_c, depth 24) ----
    set_w(0, 30, 32'h99); set_w(1, 23, 32'h77); we = 2'b11;
    edge1(); we = 2'b00;
    set_r(0, 30); set_r(1, 23); set_r(2, 14); set_r(3, 6);
    #1;
    push("oor_rd30", 32'h0);       check(pick(rdata_c, 0));
    push("oor_rd23", 32'h77);      check(pick(rdata_c, 1));
    push("oor_alias14", 32'h0);    check(pick(rdata_c, 2));
    push("oor_alias6", 32'h0);     check(pick(rdata_c, 3));
    push("inr_a30", 32'h99);       check(pick(rdata_a, 0));

    if (sb.size() != 0) begin
      ntests++;
      nfail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
